// File: rtl/axi_pkg.sv
// Shared AXI constants, read-state encoding and burst legality helper.
// Used by the read slave and the burst address generator.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] LOCK_NORMAL = 2'b00;
  localparam logic [1:0] LOCK_EXCL   = 2'b01;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_LOAD,
    RD_SEND
  } rd_state_t;

  // Wrap bursts need a power-of-two beat count and a size-aligned start.
  function automatic logic burst_bad(
    input logic [1:0] burst,
    input logic [3:0] len,
    input logic [2:0] size,
    input logic [1:0] addr_lo
  );
    logic bad_len;
    logic bad_align;
    bad_len   = !(len == 4'd1 || len == 4'd3 ||
                  len == 4'd7 || len == 4'd15);
    bad_align = (size == 3'd1 && addr_lo[0]) ||
                (size == 3'd2 && addr_lo != 2'b00);
    return (burst == 2'b11) || (size > 3'd2) ||
           (burst == BURST_WRAP && (bad_len || bad_align));
  endfunction

endpackage

// File: rtl/axi_read_slave_if.sv
// AXI3 read address / read data channel bundle.
// Master drives AR and RREADY; slave drives ARREADY and R.
interface axi_read_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [3:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [1:0]        ARLOCK;
  logic [3:0]        ARCACHE;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
    output ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
    input  ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Shared between the read and write slaves.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [3:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] mask;

  assign step = ADDR_W'(1) << size;
  assign incr = addr + step;
  // Wrap window is (len+1) beats, a power of two for legal bursts.
  assign mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);

  always_comb begin
    next_addr = incr;
    unique case (1'b1)
      burst == BURST_FIXED: next_addr = addr;
      burst == BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
      default:              next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_read_slave.sv
// AXI3 read responder: one AR at a time, one memory fetch per beat.
// Define AXI_READ_SLV_EXCL_EN to answer exclusive reads with EXOKAY.
module axi_read_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  axi_read_slave_if.slave   bus,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  rd_state_t state, next_state;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] next_addr;
  logic [3:0]        len_q;
  logic [3:0]        cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              bad_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;
  logic [1:0]        ok_resp;
  logic              unused_ok;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

`ifdef AXI_READ_SLV_EXCL_EN
  logic [1:0] lock_q;
  assign ok_resp = (lock_q == LOCK_EXCL) ? RESP_EXOKAY : RESP_OKAY;
  always_ff @(posedge ACLK) begin
    if (ARESET)
      lock_q <= LOCK_NORMAL;
    else if (state == RD_IDLE && bus.ARVALID)
      lock_q <= bus.ARLOCK;
  end
`else
  assign ok_resp = RESP_OKAY;
`endif

  assign unused_ok = ^{bus.ARCACHE, bus.ARPROT, bus.ARLOCK};

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= RD_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      RD_IDLE:  if (bus.ARVALID) next_state = RD_FETCH;
      RD_FETCH: next_state = RD_LOAD;
      RD_LOAD:  next_state = RD_SEND;
      RD_SEND:
        if (bus.RREADY)
          next_state = rlast_q ? RD_IDLE : RD_FETCH;
      default:  next_state = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      bad_q   <= 1'b0;
      rid_q   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      rlast_q <= 1'b0;
    end else begin
      unique case (state)
        RD_IDLE:
          if (bus.ARVALID) begin
            addr_q  <= bus.ARADDR;
            len_q   <= bus.ARLEN;
            cnt_q   <= '0;
            size_q  <= bus.ARSIZE;
            burst_q <= bus.ARBURST;
            rid_q   <= bus.ARID;
            bad_q   <= burst_bad(bus.ARBURST, bus.ARLEN,
                                 bus.ARSIZE, bus.ARADDR[1:0]);
          end
        RD_LOAD: begin
          rdata_q <= bad_q ? '0 : mem_rdata;
          rresp_q <= bad_q ? RESP_SLVERR : ok_resp;
          rlast_q <= (cnt_q == len_q);
        end
        RD_SEND:
          if (bus.RREADY) begin
            if (rlast_q) begin
              rlast_q <= 1'b0;
            end else begin
              addr_q <= next_addr;
              cnt_q  <= cnt_q + 4'd1;
            end
          end
        default: ;
      endcase
    end
  end

  assign bus.ARREADY = (state == RD_IDLE) && !ARESET;
  assign bus.RVALID  = (state == RD_SEND);
  assign bus.RID     = rid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;
  assign bus.RLAST   = rlast_q;
  assign mem_rd_en   = (state == RD_FETCH) && !bad_q;
  assign mem_addr    = addr_q;

endmodule

// File: tb/tb_axi_read_slave.sv
// Directed bench for axi_read_slave with a registered memory model.
// Memory word at byte address a reads back as 0xDEAD0000 | a[15:0].
module tb_axi_read_slave;
  import axi_pkg::*;

`ifdef AXI_READ_SLV_EXCL_EN
  localparam logic [1:0] LOCK_RESP = RESP_EXOKAY;
`else
  localparam logic [1:0] LOCK_RESP = RESP_OKAY;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] acc_q[$];
  logic [31:0] exp_q[$];

  axi_read_slave_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

  axi_read_slave #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .bus       (bus),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd_en) mem_rdata <= 32'hDEAD0000 | {16'h0, mem_addr[15:0]};

  always @(negedge clk)
    if (mem_rd_en) acc_q.push_back(mem_addr);

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return 32'hDEAD0000 | {16'h0, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] brst, input logic [1:0] lock);
    int t = 0;
    @(negedge clk);
    bus.ARID    = id;
    bus.ARADDR  = addr;
    bus.ARLEN   = len;
    bus.ARSIZE  = size;
    bus.ARBURST = brst;
    bus.ARLOCK  = lock;
    bus.ARVALID = 1'b1;
    while (!bus.ARREADY && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("arready_wait", 64'(t < 50), 64'd1);
    @(posedge clk);
    #1 bus.ARVALID = 1'b0;
  endtask

  task automatic get_beat(output logic [31:0] d, output logic [1:0] r,
                          output logic l, output logic [3:0] id,
                          output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.RVALID && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) check("rvalid_timeout", 64'd0, 64'd1);
    d  = bus.RDATA;
    r  = bus.RRESP;
    l  = bus.RLAST;
    id = bus.RID;
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input string tag, input logic [3:0] id,
                           input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] brst,
                           input logic [1:0] lock,
                           input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
    logic [3:0]  rid;
    int          lat;
    bit          err;
    err = (exp_resp == RESP_SLVERR);
    acc_q.delete();
    ar_send(id, addr, len, size, brst, lock);
    for (int i = 0; i <= int'(len); i++) begin
      get_beat(d, r, l, rid, lat);
      check({tag, "_data"}, 64'(d), err ? 64'd0 : 64'(mdat(exp_q[i])));
      check({tag, "_resp"}, 64'(r), 64'(exp_resp));
      check({tag, "_last"}, 64'(l), 64'(i == int'(len)));
      check({tag, "_rid"}, 64'(rid), 64'(id));
      check({tag, "_lat"}, 64'(lat), 64'd2);
    end
    check({tag, "_nacc"}, 64'(acc_q.size()),
          err ? 64'd0 : 64'(int'(len) + 1));
    if (!err)
      for (int i = 0; i <= int'(len); i++)
        if (i < acc_q.size())
          check({tag, "_maddr"}, 64'(acc_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
    logic [3:0]  rid;
    int          lat;
    int          t;
    int          stray;

    rst         = 1'b1;
    bus.ARID    = '0;
    bus.ARADDR  = '0;
    bus.ARLEN   = '0;
    bus.ARSIZE  = '0;
    bus.ARBURST = '0;
    bus.ARLOCK  = '0;
    bus.ARCACHE = '0;
    bus.ARPROT  = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_arready", 64'(bus.ARREADY), 64'd0);
    check("rst_rvalid", 64'(bus.RVALID), 64'd0);
    check("rst_rlast", 64'(bus.RLAST), 64'd0);
    check("rst_rid", 64'(bus.RID), 64'd0);
    check("rst_rdata", 64'(bus.RDATA), 64'd0);
    check("rst_rresp", 64'(bus.RRESP), 64'd0);
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_arready", 64'(bus.ARREADY), 64'd1);

    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    run_burst("incr", 4'd5, 32'h100, 4'd3, 3'd2, BURST_INCR,
              LOCK_NORMAL, RESP_OKAY);

    exp_q = '{32'h108, 32'h10C, 32'h100, 32'h104};
    run_burst("wrap4", 4'd3, 32'h108, 4'd3, 3'd2, BURST_WRAP,
              LOCK_NORMAL, RESP_OKAY);

    exp_q = '{32'h0, 32'h0, 32'h0};
    run_burst("rsvd", 4'd7, 32'h100, 4'd2, 3'd2, 2'b11,
              LOCK_NORMAL, RESP_SLVERR);

    exp_q = '{32'h50, 32'h50, 32'h50};
    run_burst("fixed", 4'd1, 32'h50, 4'd2, 3'd2, BURST_FIXED,
              LOCK_NORMAL, RESP_OKAY);

    exp_q = '{32'hFFFF_FFFC, 32'h0};
    run_burst("roll", 4'd2, 32'hFFFF_FFFC, 4'd1, 3'd2, BURST_INCR,
              LOCK_NORMAL, RESP_OKAY);

    exp_q = '{32'h11, 32'h12, 32'h13};
    run_burst("byte", 4'd4, 32'h11, 4'd2, 3'd0, BURST_INCR,
              LOCK_NORMAL, RESP_OKAY);

    exp_q = '{32'h206, 32'h204};
    run_burst("wrap_hw", 4'd6, 32'h206, 4'd1, 3'd1, BURST_WRAP,
              LOCK_NORMAL, RESP_OKAY);

    exp_q = '{32'h13C, 32'h100, 32'h104, 32'h108,
              32'h10C, 32'h110, 32'h114, 32'h118,
              32'h11C, 32'h120, 32'h124, 32'h128,
              32'h12C, 32'h130, 32'h134, 32'h138};
    run_burst("wrap16", 4'd8, 32'h13C, 4'd15, 3'd2, BURST_WRAP,
              LOCK_NORMAL, RESP_OKAY);

    exp_q = '{32'h0, 32'h0};
    run_burst("wrap_misal", 4'd9, 32'h102, 4'd1, 3'd2, BURST_WRAP,
              LOCK_NORMAL, RESP_SLVERR);

    exp_q = '{32'h0, 32'h0, 32'h0};
    run_burst("wrap_len3", 4'd10, 32'h100, 4'd2, 3'd2, BURST_WRAP,
              LOCK_NORMAL, RESP_SLVERR);

    exp_q = '{32'h0};
    run_burst("size8", 4'd11, 32'h100, 4'd0, 3'd3, BURST_INCR,
              LOCK_NORMAL, RESP_SLVERR);

    exp_q = '{32'h60};
    run_burst("excl", 4'd12, 32'h60, 4'd0, 3'd2, BURST_INCR,
              LOCK_EXCL, LOCK_RESP);

    // Back-pressure on the second beat.
    acc_q.delete();
    ar_send(4'd9, 32'h200, 4'd1, 3'd2, BURST_INCR, LOCK_NORMAL);
    get_beat(d, r, l, rid, lat);
    check("bp_b0_data", 64'(d), 64'h0000_0000_DEAD_0200);
    check("bp_b0_last", 64'(l), 64'd0);
    bus.RREADY = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.RVALID && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_wait", 64'(t < 50), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_rvalid", 64'(bus.RVALID), 64'd1);
      check("bp_rdata", 64'(bus.RDATA), 64'h0000_0000_DEAD_0204);
      check("bp_rlast", 64'(bus.RLAST), 64'd1);
      check("bp_arready", 64'(bus.ARREADY), 64'd0);
    end
    bus.RREADY = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_done_rvalid", 64'(bus.RVALID), 64'd0);
    check("bp_done_arready", 64'(bus.ARREADY), 64'd1);
    check("bp_nacc", 64'(acc_q.size()), 64'd2);

    // Reset in the middle of an 8-beat burst.
    ar_send(4'd2, 32'h300, 4'd7, 3'd2, BURST_INCR, LOCK_NORMAL);
    bus.RREADY = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.RVALID && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("mid_wait", 64'(t < 50), 64'd1);
    check("mid_b0_data", 64'(bus.RDATA), 64'h0000_0000_DEAD_0300);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.RREADY = 1'b1;
    @(negedge clk);
    check("mid_rvalid", 64'(bus.RVALID), 64'd0);
    check("mid_rdata", 64'(bus.RDATA), 64'd0);
    check("mid_rid", 64'(bus.RID), 64'd0);
    check("mid_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("mid_arready", 64'(bus.ARREADY), 64'd1);
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.RVALID) stray++;
    end
    check("mid_stray", 64'(stray), 64'd0);

    exp_q = '{32'h40};
    run_burst("post_abort", 4'd1, 32'h40, 4'd0, 3'd2, BURST_INCR,
              LOCK_NORMAL, RESP_OKAY);
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.RVALID) stray++;
    end
    check("post_abort_stray", 64'(stray), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_slave.md
# axi_read_slave

AXI3-style read-channel responder: accepts one read address (AR) transaction at a time, walks the burst address sequence, fetches each beat from a single-port synchronous memory and returns it on the R channel. It is the read-direction counterpart of the write slave inside the write master/slave wrapper. It connects the interconnect's AR/R wires to the local memory read port.

## Interface
- ADDR_W, 32, AR/memory address width
- DATA_W, 32, RDATA/memory data width; fixed 32, bytes per beat max 4
- ID_W, 4, ARID/RID width
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- ARID  in  ID_W  transaction ID
- ARADDR  in  ADDR_W  start byte address
- ARLEN  in  4  beats minus one
- ARSIZE  in  3  log2 bytes per beat
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- ARLOCK  in  2  00 normal, 01 exclusive
- ARCACHE  in  4  accepted, ignored
- ARPROT  in  3  accepted, ignored
- ARVALID  in  1  address valid
- ARREADY  out  1  address accept
- RID  out  ID_W  echoed ARID
- RDATA  out  DATA_W  read data
- RRESP  out  2  00 OKAY, 01 EXOKAY, 10 SLVERR
- RLAST  out  1  final beat
- RVALID  out  1  data valid
- RREADY  in  1  master accept
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory byte address
- mem_rdata  in  DATA_W  memory data, valid the cycle after mem_rd_en

## Operation
- States: IDLE, FETCH, LOAD, SEND. IDLE: ARREADY=1; on ARVALID latch ID/addr/len/size/burst/lock, beat counter=0, check legality, go FETCH.
- Illegal (burst-wide SLVERR): ARBURST=11; ARSIZE>2; WRAP with ARLEN not in {1,3,7,15}; WRAP with ARADDR not aligned to 2^ARSIZE.
- FETCH: mem_rd_en=1 (0 if burst illegal), mem_addr=current address; go LOAD.
- LOAD: RDATA<=mem_rdata (0 if illegal), RRESP set, RLAST<=(counter==len); go SEND.
- SEND: RVALID=1, all R outputs held stable until RREADY. On handshake: if RLAST go IDLE, else advance address, counter+1, go FETCH.
- Address: FIXED unchanged; INCR addr+2^size, modulo 2^ADDR_W; WRAP addr+2^size within window of (len+1)*2^size bytes aligned to that size, wrapping to window base.
- Illegal bursts still return exactly ARLEN+1 beats, all SLVERR, no memory access.

## Timing
- Reset: ARREADY=0 during reset cycle, 1 the cycle after; RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=00, mem_rd_en=0, mem_addr=0, state IDLE.
- AR handshake at edge T -> mem_rd_en high cycle T+1 -> RVALID high from T+3.
- R handshake at edge T (non-last) -> next RVALID from T+3; one beat per 3 cycles minimum.
- R handshake with RLAST at edge T -> ARREADY=1 from T+1; no AR accepted while not IDLE.
- RREADY low: RVALID stays high, no memory access, no output change.
- ARESET mid-burst: burst aborted, all outputs to reset values next edge, no residual beats.

## Configuration
- AXI_READ_SLV_EXCL_EN defined: ARLOCK=01 on legal burst gives RRESP=01 (EXOKAY) on every beat; ARLOCK=00 gives OKAY.
- Undefined: ARLOCK ignored, legal bursts always OKAY.

## Structure
- Shared package axi_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/EXOKAY/SLVERR/DECERR, LOCK_NORMAL/EXCL constants; read-state enum.
- Sub-module axi_burst_addr_gen: combinational next-address from current addr, size, len, burst; reusable by the write slave.

## Test plan
- INCR ARADDR=0x100, ARLEN=3, ARSIZE=2, RREADY=1 -> mem_addr 0x100,0x104,0x108,0x10C; 4 OKAY beats, RLAST on 4th only, RID=ARID.
- WRAP ARADDR=0x108, ARLEN=3, ARSIZE=2 -> mem_addr 0x108,0x10C,0x100,0x104.
- ARBURST=11, ARLEN=2 -> 3 beats RRESP=10, RDATA=0, mem_rd_en never high.
- RREADY low 5 cycles on beat 2 of INCR ARLEN=1 -> RVALID/RDATA held, single mem_rd_en per beat, ARREADY stays 0.
- ARESET asserted one cycle during SEND of beat 1 of ARLEN=7 -> next cycle RVALID=0, state IDLE, following ARLEN=0 read returns one beat.
- ARLOCK=01 INCR ARLEN=0 -> RRESP=01 with AXI_READ_SLV_EXCL_EN, 00 without.
